// File: rtl/rob_nway_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_nway_pkg
// Description : Shared types and helpers for the parametrised reorder buffer.
//               The entry struct carries control/branch fields only; result
//               data lives in a separate XLEN-wide array in the top level so
//               the struct stays independent of the XLEN parameter.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_nway_pkg;

    localparam int c_REG_W = 5;   // architectural register index width
    localparam int c_PC_W  = 32;  // redirect target width

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               has_rd;
        logic [c_REG_W-1:0] rd;
        logic               is_br;
        logic               mispred;
        logic [c_PC_W-1:0]  target;
    } rob_entry_t;

    // Tag width for a given depth; a one-entry buffer still needs one bit
    function automatic int tag_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_commit_sel.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_sel
// Description : Combinational commit window selector. Given the COMMIT_W
//               entries starting at head, produces a contiguous retire mask
//               and the flush request raised by a retiring mispredicted
//               branch (which still retires, but blocks younger slots).
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_sel
    import rob_nway_pkg::*;
#(
    parameter int COMMIT_W = 2
) (
    input  rob_entry_t          i_win [COMMIT_W],
    output logic [COMMIT_W-1:0] o_commit_mask,
    output logic                o_flush,
    output logic [c_PC_W-1:0]   o_flush_pc
);

    // Walk the window oldest-first; the first not-ready entry or the first
    // retiring mispredicted branch closes the window for all younger slots
    always_comb begin : p_select
        logic w_open;
        o_commit_mask = '0;
        o_flush       = 1'b0;
        o_flush_pc    = '0;
        w_open        = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (w_open && i_win[i].valid && i_win[i].done) begin
                o_commit_mask[i] = 1'b1;
                if (i_win[i].is_br && i_win[i].mispred) begin
                    o_flush    = 1'b1;
                    o_flush_pc = i_win[i].target;
                    w_open     = 1'b0;
                end
            end else begin
                w_open = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_nway.sv
`default_nettype none
// ============================================================================
// Module      : rob_nway
// Description : Parametrised reorder buffer: single issue per cycle,
//               NUM_CDB result write ports, branch resolution tracking and
//               up to COMMIT_W in-order retirements per cycle with flush on
//               a retiring mispredicted branch.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_nway
    import rob_nway_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NUM_CDB  = 5,
    parameter int COMMIT_W = 2,
    parameter int XLEN     = 32,
    parameter int TAG_W    = tag_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic                        issue_has_rd,
    input  logic [4:0]                  issue_rd,
    input  logic                        issue_is_br,
    output logic                        issue_ready,
    output logic [TAG_W-1:0]            issue_tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_data,
    input  logic                        br_valid,
    input  logic [TAG_W-1:0]            br_tag,
    input  logic                        br_mispredict,
    input  logic [31:0]                 br_target,
    output logic [COMMIT_W-1:0]         commit_valid,
    output logic [COMMIT_W-1:0]         commit_has_rd,
    output logic [COMMIT_W*5-1:0]       commit_rd,
    output logic [COMMIT_W*XLEN-1:0]    commit_data,
    output logic [COMMIT_W*TAG_W-1:0]   commit_tag,
    output logic                        flush_valid,
    output logic [31:0]                 flush_pc,
    output logic [TAG_W:0]              count,
    output logic                        empty
);

    localparam logic [TAG_W:0] c_FULL = (TAG_W+1)'(DEPTH);

    rob_entry_t          r_ent  [DEPTH];
    logic [XLEN-1:0]     r_data [DEPTH];
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic [TAG_W-1:0]    w_win_tag [COMMIT_W];
    rob_entry_t          w_win     [COMMIT_W];
    logic [COMMIT_W-1:0] w_mask;
    logic                w_flush;
    logic [31:0]         w_flush_pc;
    logic [TAG_W:0]      w_ncommit;
    logic                w_issue_fire;

    // Commit window: the COMMIT_W entries starting at head, wrapping mod DEPTH
    generate
        for (genvar i = 0; i < COMMIT_W; i++) begin : g_win
            assign w_win_tag[i]                  = r_head + TAG_W'(i);
            assign w_win[i]                      = r_ent[w_win_tag[i]];
            assign commit_has_rd[i]              = w_win[i].has_rd;
            assign commit_rd[i*5 +: 5]           = w_win[i].rd;
            assign commit_data[i*XLEN +: XLEN]   = r_data[w_win_tag[i]];
            assign commit_tag[i*TAG_W +: TAG_W]  = w_win_tag[i];
        end
    endgenerate

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W)
    ) u_commit_sel (
        .i_win         (w_win),
        .o_commit_mask (w_mask),
        .o_flush       (w_flush),
        .o_flush_pc    (w_flush_pc)
    );

    assign commit_valid = w_mask;
    assign flush_valid  = w_flush;
    assign flush_pc     = w_flush_pc;
    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign issue_tag    = r_tail;
    // No commit bypass: a full buffer refuses issue even while retiring
    assign issue_ready  = (r_count < c_FULL) && !w_flush;
    assign w_issue_fire = issue_valid && issue_ready;

    // Number of retiring slots; the mask is contiguous so a popcount suffices
    always_comb begin
        w_ncommit = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_ncommit = w_ncommit + {{TAG_W{1'b0}}, w_mask[i]};
        end
    end

    // Entry state, pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_ent[d] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Highest port first so the lowest-index writer lands last and wins
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && r_ent[cdb_tag[p*TAG_W +: TAG_W]].valid) begin
                    r_ent[cdb_tag[p*TAG_W +: TAG_W]].done <= 1'b1;
                    r_data[cdb_tag[p*TAG_W +: TAG_W]]     <= cdb_data[p*XLEN +: XLEN];
                end
            end
            if (br_valid && r_ent[br_tag].valid && r_ent[br_tag].is_br) begin
                r_ent[br_tag].done    <= 1'b1;
                r_ent[br_tag].mispred <= br_mispredict;
                r_ent[br_tag].target  <= br_target;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (w_mask[i]) begin
                    r_ent[w_win_tag[i]].valid <= 1'b0;
                end
            end
            // Tail is never a live entry when issue is allowed, so no overlap
            if (w_issue_fire) begin
                r_ent[r_tail] <= '{valid:   1'b1,
                                   done:    !issue_is_br && !issue_has_rd,
                                   has_rd:  issue_has_rd,
                                   rd:      issue_rd,
                                   is_br:   issue_is_br,
                                   mispred: 1'b0,
                                   target:  '0};
            end
            r_head  <= r_head + w_ncommit[TAG_W-1:0];
            r_tail  <= r_tail + TAG_W'(w_issue_fire);
            r_count <= r_count + {{TAG_W{1'b0}}, w_issue_fire} - w_ncommit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_nway
// Description : Scoreboard bench for rob_nway. Directed stimulus pushes the
//               expected retirements; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_nway;

    localparam int DEPTH = 32;
    localparam int NCDB  = 5;
    localparam int CW    = 2;
    localparam int XLEN  = 32;
    localparam int TW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 issue_valid, issue_has_rd, issue_is_br;
    logic [4:0]           issue_rd;
    logic                 issue_ready;
    logic [TW-1:0]        issue_tag;
    logic [NCDB-1:0]      cdb_valid;
    logic [NCDB*TW-1:0]   cdb_tag;
    logic [NCDB*XLEN-1:0] cdb_data;
    logic                 br_valid, br_mispredict;
    logic [TW-1:0]        br_tag;
    logic [31:0]          br_target;
    logic [CW-1:0]        commit_valid, commit_has_rd;
    logic [CW*5-1:0]      commit_rd;
    logic [CW*XLEN-1:0]   commit_data;
    logic [CW*TW-1:0]     commit_tag;
    logic                 flush_valid;
    logic [31:0]          flush_pc;
    logic [TW:0]          count;
    logic                 empty;

    rob_nway #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .COMMIT_W(CW), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_is_br(issue_is_br), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .br_target(br_target),
        .commit_valid(commit_valid), .commit_has_rd(commit_has_rd), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic          has_rd;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          flush;
        logic [31:0]   pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int tag, input logic has_rd, input int rd, input int data,
                        input logic flush, input int pc);
        exp_t e;
        e.tag = TW'(tag); e.has_rd = has_rd; e.rd = 5'(rd);
        e.data = data; e.flush = flush; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic has_rd, input int rd, input logic is_br);
        issue_valid = 1'b1; issue_has_rd = has_rd; issue_rd = 5'(rd); issue_is_br = is_br;
        cyc();
        issue_valid = 1'b0; issue_has_rd = 1'b0; issue_is_br = 1'b0;
    endtask

    task automatic set_cdb(input int p, input int tag, input int data);
        cdb_valid[p]           = 1'b1;
        cdb_tag[p*TW +: TW]    = TW'(tag);
        cdb_data[p*XLEN +: XLEN] = data;
    endtask

    task automatic clr_cdb();
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Monitor: pop one expectation per retiring slot, oldest slot first
    always @(negedge clk) begin : p_monitor
        exp_t        e;
        logic        exp_flush;
        logic [31:0] exp_pc;
        if (!rst && commit_valid != '0) begin
            exp_flush = 1'b0;
            exp_pc    = '0;
            for (int i = 0; i < CW; i++) begin
                if (commit_valid[i]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_commit: slot %0d tag %0d, expected nothing",
                                 i, commit_tag[i*TW +: TW]);
                    end else begin
                        e = sb.pop_front();
                        chk("commit_tag", 64'(commit_tag[i*TW +: TW]), 64'(e.tag));
                        chk("commit_has_rd", 64'(commit_has_rd[i]), 64'(e.has_rd));
                        if (e.has_rd) begin
                            chk("commit_rd", 64'(commit_rd[i*5 +: 5]), 64'(e.rd));
                            chk("commit_data", 64'(commit_data[i*XLEN +: XLEN]), 64'(e.data));
                        end
                        if (e.flush) begin
                            exp_flush = 1'b1;
                            exp_pc    = e.pc;
                        end
                    end
                end
            end
            chk("flush_valid", 64'(flush_valid), 64'(exp_flush));
            if (exp_flush) chk("flush_pc", 64'(flush_pc), 64'(exp_pc));
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int exp_cnt [4];
        rst = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0; issue_is_br = 1'b0;
        br_valid = 1'b0; br_tag = '0; br_mispredict = 1'b0; br_target = '0;
        clr_cdb();

        // ---- 1: reset state, fill to full, 33rd issue ignored ----
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_issue_tag", 64'(issue_tag), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_flush_valid", 64'(flush_valid), 64'd0);
        for (int k = 0; k < 32; k++) begin
            chk("fill_issue_tag", 64'(issue_tag), 64'(k));
            issue(1'b1, 3, 1'b0);
        end
        chk("full_count", 64'(count), 64'd32);
        chk("full_issue_ready", 64'(issue_ready), 64'd0);
        chk("full_empty", 64'(empty), 64'd0);
        issue(1'b1, 3, 1'b0);
        chk("full_33rd_count", 64'(count), 64'd32);
        chk("full_33rd_tag", 64'(issue_tag), 64'd0);

        // ---- 2: dual commit after out-of-order CDB writes ----
        do_reset();
        for (int k = 0; k < 4; k++) issue(1'b1, k + 1, 1'b0);
        push(0, 1'b1, 1, 32'hB, 1'b0, 0);
        push(1, 1'b1, 2, 32'hA, 1'b0, 0);
        set_cdb(0, 1, 32'hA);
        set_cdb(1, 0, 32'hB);
        cyc();
        clr_cdb();
        chk("t2_commit_valid", 64'(commit_valid), 64'b11);
        cyc();
        cyc();
        chk("t2_tag2_waits", 64'(commit_valid), 64'd0);
        chk("t2_count", 64'(count), 64'd2);
        push(2, 1'b1, 3, 32'hC, 1'b0, 0);
        push(3, 1'b1, 4, 32'hD, 1'b0, 0);
        set_cdb(2, 2, 32'hC);
        set_cdb(4, 3, 32'hD);
        cyc();
        clr_cdb();
        cyc();
        chk("t2_drain_count", 64'(count), 64'd0);
        chk("t2_sb_drained", 64'(sb.size()), 64'd0);

        // ---- 3: same-tag conflict, lowest port wins ----
        do_reset();
        for (int k = 0; k < 6; k++) issue(1'b1, 10 + k, 1'b0);
        for (int k = 0; k < 5; k++) begin
            push(k, 1'b1, 10 + k, 32'h100 + k, 1'b0, 0);
            set_cdb(k, k, 32'h100 + k);
        end
        push(5, 1'b1, 15, 32'h11, 1'b0, 0);
        cyc();
        clr_cdb();
        set_cdb(0, 5, 32'h11);
        set_cdb(3, 5, 32'h22);
        cyc();
        clr_cdb();
        for (int k = 0; k < 4; k++) cyc();
        chk("t3_count", 64'(count), 64'd0);
        chk("t3_sb_drained", 64'(sb.size()), 64'd0);

        // ---- 4: mispredicted branch flushes younger entries ----
        do_reset();
        push(0, 1'b0, 0, 0, 1'b0, 0);
        push(1, 1'b0, 0, 0, 1'b0, 0);
        issue(1'b0, 0, 1'b0);
        issue(1'b0, 0, 1'b0);
        issue(1'b0, 0, 1'b1);
        issue(1'b0, 0, 1'b0);
        issue(1'b0, 0, 1'b0);
        cyc();
        cyc();
        chk("t4_pre_count", 64'(count), 64'd3);
        chk("t4_branch_blocks", 64'(commit_valid), 64'd0);
        push(2, 1'b0, 0, 0, 1'b1, 32'h60);
        br_valid = 1'b1; br_tag = 5'd2; br_mispredict = 1'b1; br_target = 32'h60;
        cyc();
        br_valid = 1'b0; br_mispredict = 1'b0;
        chk("t4_commit_valid", 64'(commit_valid), 64'b01);
        chk("t4_flush_valid", 64'(flush_valid), 64'd1);
        chk("t4_flush_pc", 64'(flush_pc), 64'h60);
        chk("t4_issue_blocked", 64'(issue_ready), 64'd0);
        issue(1'b1, 7, 1'b0);
        chk("t4_post_count", 64'(count), 64'd0);
        chk("t4_post_empty", 64'(empty), 64'd1);
        chk("t4_post_issue_tag", 64'(issue_tag), 64'd0);
        chk("t4_post_ready", 64'(issue_ready), 64'd1);
        chk("t4_sb_drained", 64'(sb.size()), 64'd0);

        // ---- 5: wrap-around with 2 commits + 1 issue per cycle ----
        do_reset();
        for (int k = 0; k < 30; k++) begin
            push(k, 1'b0, 0, 0, 1'b0, 0);
            issue(1'b0, 0, 1'b0);
        end
        cyc();
        cyc();
        chk("t5_prefill_count", 64'(count), 64'd0);
        chk("t5_prefill_tag", 64'(issue_tag), 64'd30);
        for (int k = 0; k < 32; k++) issue(1'b1, 7, 1'b0);
        chk("t5_full_count", 64'(count), 64'd32);
        exp_cnt[0] = 32; exp_cnt[1] = 30; exp_cnt[2] = 29; exp_cnt[3] = 28;
        for (int k = 0; k < 4; k++) begin
            push((30 + 2*k) % 32, 1'b1, 7, 32'h1000 + (30 + 2*k) % 32, 1'b0, 0);
            push((31 + 2*k) % 32, 1'b1, 7, 32'h1000 + (31 + 2*k) % 32, 1'b0, 0);
            set_cdb(0, (30 + 2*k) % 32, 32'h1000 + (30 + 2*k) % 32);
            set_cdb(1, (31 + 2*k) % 32, 32'h1000 + (31 + 2*k) % 32);
            issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
            cyc();
            chk("t5_wrap_count", 64'(count), 64'(exp_cnt[k]));
        end
        issue_valid = 1'b0; issue_has_rd = 1'b0;
        clr_cdb();
        cyc();
        chk("t5_final_count", 64'(count), 64'd26);
        chk("t5_final_tag", 64'(issue_tag), 64'd0);
        chk("t5_sb_drained", 64'(sb.size()), 64'd0);

        // ---- 6: reset mid-operation overrides CDB writes ----
        do_reset();
        for (int k = 0; k < 10; k++) issue(1'b1, k, 1'b0);
        chk("t6_pre_count", 64'(count), 64'd10);
        for (int p = 0; p < NCDB; p++) set_cdb(p, p, 32'h500 + p);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clr_cdb();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_issue_ready", 64'(issue_ready), 64'd1);
        chk("t6_commit_valid", 64'(commit_valid), 64'd0);
        chk("t6_flush_valid", 64'(flush_valid), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        cyc();
        cyc();
        chk("t6_still_idle", 64'(commit_valid), 64'd0);
        chk("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_nway.md
Name: rob_nway

Overview:
- Parametrised reorder buffer for the out-of-order RV32IM core.
- Generalises the existing ROB in three ways: configurable depth, configurable number of CDB write ports, and multi-wide in-order commit.
- Adds branch-resolution tracking with a mispredict flush.
- Sits between inst_sched (issue), the reservation stations / LD_ST unit (CDB writers) and the regfile / fetch_unit (commit and redirect).

Parameters:
- DEPTH, 32, number of entries; power of two, >=4.
- NUM_CDB, 5, number of CDB write ports.
- COMMIT_W, 2, maximum entries retired per cycle; 1..4.
- XLEN, 32, data width.
- TAG_W, $clog2(DEPTH), ROB tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  scheduler presents an instruction
- issue_has_rd  in  1  instruction writes a destination register
- issue_rd  in  5  destination register
- issue_is_br  in  1  instruction is a branch/jump needing resolution
- issue_ready  out  1  entry available
- issue_tag  out  TAG_W  tag assigned (current tail)
- cdb_valid  in  NUM_CDB  per-port result valid
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag
- cdb_data  in  NUM_CDB*XLEN  per-port result
- br_valid  in  1  branch resolved
- br_tag  in  TAG_W  resolved branch tag
- br_mispredict  in  1  resolution disagrees with prediction
- br_target  in  32  correct next PC
- commit_valid  out  COMMIT_W  per-slot retire strobe
- commit_has_rd  out  COMMIT_W  per-slot register write enable
- commit_rd  out  COMMIT_W*5  per-slot destination
- commit_data  out  COMMIT_W*XLEN  per-slot value
- commit_tag  out  COMMIT_W*TAG_W  per-slot tag
- flush_valid  out  1  pipeline flush / redirect
- flush_pc  out  32  redirect target
- count  out  TAG_W+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all entry valid/done/mispred bits cleared; head=tail=count=0. This gives issue_ready=1, issue_tag=0, commit_valid=0, flush_valid=0, empty=1. Reset overrides every same-cycle event.
- Entry fields: valid, done, has_rd, rd, is_br, mispred, target, data.
- Issue:
  - Accepted when issue_valid && issue_ready.
  - Writes entry[tail] with valid=1, done=!issue_is_br && !issue_has_rd (no-dest, non-branch ops such as stores are completed by their CDB write as well — see CDB rule), then tail++ mod DEPTH.
  - issue_ready = (count < DEPTH) && !flush_valid, computed from registered count. There is no same-cycle commit bypass, so a full ROB refuses issue even while committing.
- CDB write:
  - Any port with cdb_valid whose tag addresses a valid entry sets done=1 and data.
  - Writes to invalid entries are ignored.
  - If several ports target the same tag in one cycle, the lowest port index wins.
- Branch resolve:
  - br_valid on a valid entry with is_br set sets done=1, mispred=br_mispredict, target=br_target.
  - A CDB write to the same tag in the same cycle also lands; data comes from the CDB.
- Commit (combinational from registered state):
  - Slot i asserts when entries head..head+i are all valid && done.
  - No earlier slot in this cycle holds a mispredicted branch.
  - Slot 0 has priority; slots are contiguous (no gaps).
  - On the clock edge, head += number of slots asserted and count is updated.
- Count rule: count_next = count + issued − committed. A simultaneous issue and commit is legal whenever issue_ready=1.
- Flush:
  - flush_valid=1 in the same cycle that a commit slot retires a mispredicted branch; flush_pc=its target.
  - That branch commits; no younger slot commits that cycle.
  - Next edge: all entries invalidated, head=tail=count=0.
  - CDB and branch writes in the flush cycle are discarded; issue is blocked.
- Latency: a CDB write in cycle N can first appear on commit_valid in cycle N+1. An issue in cycle N at head with done preset can first commit in cycle N+1.
- Wrap-around: head and tail wrap mod DEPTH; full/empty is determined by count, not pointer compare.

Decomposition:
- Package rob_nway_pkg: rob_entry_t struct, and functions/localparams for tag width. New fields, if needed, also go into rob_entry_structs.
- Sub-module rob_commit_sel: purely combinational. Takes COMMIT_W entries starting at head and returns the commit mask plus flush select. Keeps the sequential core readable.

Test Plan:
1. Reset, then 32 issues with no CDB writes -> tags 0..31, issue_ready drops after the 32nd, count=32, 33rd issue is ignored.
2. Issue tags 0–3 (has_rd); CDB writes tag 1 and tag 0 data 0xA, 0xB in cycle N -> cycle N+1: commit_valid=2'b11 with tags 0,1. Tag 2 does not commit until written.
3. Ports 0 and 3 both write tag 5 in the same cycle, data 0x11 and 0x22 -> committed data is 0x11.
4. Issue branch at tag 2 followed by tags 3,4 (done). br_valid tag 2, mispredict=1, target 0x60 -> tag 2 commits with flush_valid=1 and flush_pc=0x60. Tags 3,4 never commit; next cycle count=0, empty=1.
5. Wrap: fill to 32, commit 2 per cycle while issuing 1 per cycle across the index-31→0 boundary -> commit tags remain in order 30,31,0,1; count tracks exactly.
6. Assert rst mid-operation with 10 entries and active CDB writes -> next cycle count=0, issue_ready=1, commit_valid=0, flush_valid=0.
